// File: rtl/input_conditioner.sv
// Multi-channel button/switch front-end: synchronise, optionally invert, debounce,
// then derive press/release pulses, a long-press flag and an auto-repeat pulse train.
module input_conditioner #(
    parameter int          N               = 5,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          HOLD_CYCLES     = 64,
    parameter int          REPEAT_CYCLES   = 16,
    parameter logic [N-1:0] INVERT         = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in,
    input  logic [N-1:0]   repeat_en,
    output logic [N-1:0]   out,
    output logic [N-1:0]   ondn,
    output logic [N-1:0]   onup,
    output logic [N-1:0]   long,
    output logic [N-1:0]   rpt,
    output logic [2*N-1:0] hold_state
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_e;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [TMR_W-1:0]       timer_q;
        hold_state_e            state_q;
        logic                   out_q;
        logic                   ondn_q;
        logic                   onup_q;
        logic                   long_q;
        logic                   rpt_q;
        logic                   synced;
        logic                   mismatch;
        logic                   flip;
        logic                   rise;
        logic                   fall;

        // Sync flops reset to 0 so an idle active-low pin never looks pressed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= in[i] ^ INVERT[i];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= sync_q[s-1];
                end
            end
        end

        assign synced   = sync_q[SYNC_STAGES-1];
        assign mismatch = synced != out_q;
        assign flip     = mismatch && (cnt_q == CNT_LAST);
        assign rise     = flip && !out_q;
        assign fall     = flip && out_q;

        // Debounce counter and hold FSM share one register block so the press
        // edge, the first repeat pulse and ondn all land on the same clock edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                out_q   <= 1'b0;
                ondn_q  <= 1'b0;
                onup_q  <= 1'b0;
                long_q  <= 1'b0;
                rpt_q   <= 1'b0;
                timer_q <= '0;
                state_q <= ST_IDLE;
            end else begin
                ondn_q <= rise;
                onup_q <= fall;
                rpt_q  <= 1'b0;

                if (!mismatch) begin
                    cnt_q <= '0;
                end else if (flip) begin
                    cnt_q <= '0;
                    out_q <= ~out_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end

                if (fall) begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    long_q  <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (rise) begin
                                state_q <= ST_WAIT;
                                timer_q <= '0;
                                rpt_q   <= repeat_en[i];
                            end
                        end
                        ST_WAIT: begin
                            if (timer_q == HOLD_LAST) begin
                                state_q <= ST_REPEAT;
                                timer_q <= '0;
                                long_q  <= 1'b1;
                                rpt_q   <= repeat_en[i];
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (timer_q == RPT_LAST) begin
                                timer_q <= '0;
                                rpt_q   <= repeat_en[i];
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            timer_q <= '0;
                            long_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign out[i]               = out_q;
        assign ondn[i]              = ondn_q;
        assign onup[i]              = onup_q;
        assign long[i]              = long_q;
        assign rpt[i]               = rpt_q;
        assign hold_state[2*i +: 2] = state_q;
    end

endmodule
